// File: rtl/touch_pkg.sv
// Shared types and helpers for the touch point conditioning path.
package touch_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_PEND, PRESSED, REL_PEND} touch_state_t;
    typedef enum logic [1:0] {P, H, R} sample_class_t;

    // Offset subtract (floored at 0), right shift, then clamp to the ceiling.
    function automatic int unsigned cal_axis(input int unsigned raw,
                                             input int unsigned offset,
                                             input int unsigned shift,
                                             input int unsigned max_v);
        int unsigned d;
        int unsigned s;
        d = (raw > offset) ? raw - offset : 0;
        s = d >> shift;
        return (s > max_v) ? max_v : s;
    endfunction

    function automatic sample_class_t classify(input int unsigned z,
                                               input int unsigned z_press,
                                               input int unsigned z_release);
        if (z >= z_press)
            return P;
        else if (z < z_release)
            return R;
        else
            return H;
    endfunction

endpackage

// File: rtl/moving_average.sv
// Box-car average over 2^LOG2 samples with running sum; prefill loads every slot.
module moving_average #(
    parameter int W    = 10,
    parameter int LOG2 = 2
) (
    input  logic         cclk,
    input  logic         rstb,
    input  logic         push,
    input  logic         prefill,
    input  logic [W-1:0] din,
    output logic [W-1:0] avg
);
    localparam int DEPTH = 1 << LOG2;
    localparam int SW    = W + LOG2;
    localparam int PW    = (LOG2 > 0) ? LOG2 : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [SW-1:0] sum_q;
    logic [PW-1:0] ptr_q;

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            sum_q <= '0;
            ptr_q <= '0;
        end else if (prefill) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= din;
            sum_q <= SW'(din) << LOG2;
            ptr_q <= '0;
        end else if (push) begin
            mem_q[ptr_q] <= din;
            sum_q        <= sum_q - SW'(mem_q[ptr_q]) + SW'(din);
            ptr_q        <= (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    assign avg = W'(sum_q >> LOG2);

endmodule

// File: rtl/touch_point_filter.sv
// Calibrates, debounces and averages raw touch samples; publishes on frame boundaries.
// state      | meaning
// IDLE       | not touched
// PRESS_PEND | counting consecutive pressed samples
// PRESSED    | touch active, samples feed the average
// REL_PEND   | counting consecutive release samples, still reported as down
module touch_point_filter
    import touch_pkg::*;
#(
    parameter int RAW_W     = 12,
    parameter int OUT_X_W   = 10,
    parameter int OUT_Y_W   = 9,
    parameter int X_OFFSET  = 150,
    parameter int Y_OFFSET  = 300,
    parameter int X_SHIFT   = 2,
    parameter int Y_SHIFT   = 2,
    parameter int X_MAX     = 479,
    parameter int Y_MAX     = 271,
    parameter int Z_PRESS   = 256,
    parameter int Z_RELEASE = 128,
    parameter int DEBOUNCE  = 4,
    parameter int AVG_LOG2  = 2
) (
    input  logic               cclk,
    input  logic               rstb,
    input  logic               sample_valid,
    input  logic [RAW_W-1:0]   raw_x,
    input  logic [RAW_W-1:0]   raw_y,
    input  logic [RAW_W-1:0]   raw_z,
    input  logic               new_frame,
    output logic [OUT_X_W-1:0] touch_x,
    output logic [OUT_Y_W-1:0] touch_y,
    output logic               touch_down,
    output logic               touch_valid,
    output logic               press_event,
    output logic               release_event
);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    touch_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    sample_class_t  cls;
    logic           press_d, release_d, push, prefill, down_now;
    logic [OUT_X_W-1:0] c_x, avg_x;
    logic [OUT_Y_W-1:0] c_y, avg_y;

    assign c_x = OUT_X_W'(cal_axis(32'(raw_x), X_OFFSET, X_SHIFT, X_MAX));
    assign c_y = OUT_Y_W'(cal_axis(32'(raw_y), Y_OFFSET, Y_SHIFT, Y_MAX));
    assign cls = classify(32'(raw_z), Z_PRESS, Z_RELEASE);
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign down_now = (state_q == PRESSED) || (state_q == REL_PEND);

    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        push      = 1'b0;
        prefill   = 1'b0;
        if (sample_valid) begin
            case (state_q)
                IDLE: begin
                    if (cls == P) begin
                        if (DEBOUNCE == 1) begin
                            state_d = PRESSED;
                            cnt_d   = '0;
                            press_d = 1'b1;
                            prefill = 1'b1;
                        end else begin
                            state_d = PRESS_PEND;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PRESS_PEND: begin
                    if (cls != P) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        prefill = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (cls == R) begin
                        if (DEBOUNCE == 1) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            release_d = 1'b1;
                        end else begin
                            state_d = REL_PEND;
                            cnt_d   = CNT_W'(1);
                        end
                    end else begin
                        push = 1'b1;
                    end
                end
                REL_PEND: begin
                    if (cls != R) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        push    = 1'b1;
                    end else if (cnt_inc == CNT_W'(DEBOUNCE)) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    moving_average #(.W(OUT_X_W), .LOG2(AVG_LOG2)) u_avg_x (
        .cclk(cclk), .rstb(rstb), .push(push), .prefill(prefill), .din(c_x), .avg(avg_x)
    );

    moving_average #(.W(OUT_Y_W), .LOG2(AVG_LOG2)) u_avg_y (
        .cclk(cclk), .rstb(rstb), .push(push), .prefill(prefill), .din(c_y), .avg(avg_y)
    );

    // Publish uses pre-edge state and average, so a coincident sample lands next frame.
    always_ff @(posedge cclk or negedge rstb) begin
        if (!rstb) begin
            touch_x       <= '0;
            touch_y       <= '0;
            touch_down    <= 1'b0;
            touch_valid   <= 1'b0;
            press_event   <= 1'b0;
            release_event <= 1'b0;
        end else begin
            press_event   <= press_d;
            release_event <= release_d;
            touch_valid   <= new_frame && down_now;
            if (new_frame) begin
                touch_down <= down_now;
                if (down_now) begin
                    touch_x <= avg_x;
                    touch_y <= avg_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_touch_point_filter.sv
// Directed bench for touch_point_filter with a frame-expectation scoreboard.
module tb_touch_point_filter;

    logic        cclk = 1'b0;
    logic        rstb = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] raw_x = '0;
    logic [11:0] raw_y = '0;
    logic [11:0] raw_z = '0;
    logic        new_frame = 1'b0;
    logic [9:0]  touch_x;
    logic [8:0]  touch_y;
    logic        touch_down;
    logic        touch_valid;
    logic        press_event;
    logic        release_event;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        int    x;
        int    y;
        int    down;
        int    valid;
    } frame_exp_t;

    frame_exp_t exp_q[$];

    touch_point_filter dut (
        .cclk(cclk), .rstb(rstb), .sample_valid(sample_valid),
        .raw_x(raw_x), .raw_y(raw_y), .raw_z(raw_z), .new_frame(new_frame),
        .touch_x(touch_x), .touch_y(touch_y), .touch_down(touch_down),
        .touch_valid(touch_valid), .press_event(press_event), .release_event(release_event)
    );

    always #5 cclk = ~cclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge cclk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".x"}, int'(touch_x), 0);
        chk({tag, ".y"}, int'(touch_y), 0);
        chk({tag, ".down"}, int'(touch_down), 0);
        chk({tag, ".valid"}, int'(touch_valid), 0);
        chk({tag, ".press"}, int'(press_event), 0);
        chk({tag, ".release"}, int'(release_event), 0);
    endtask

    task automatic sample(input string tag, input int x, input int y, input int z,
                          input int exp_p, input int exp_r);
        raw_x = 12'(x);
        raw_y = 12'(y);
        raw_z = 12'(z);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk({tag, ".press"}, int'(press_event), exp_p);
        chk({tag, ".release"}, int'(release_event), exp_r);
    endtask

    task automatic frame(input string tag, input int ex, input int ey, input int ed,
                         input int ev, input bit with_sample = 1'b0,
                         input int x = 0, input int y = 0, input int z = 0);
        frame_exp_t e;
        e = '{tag, ex, ey, ed, ev};
        exp_q.push_back(e);
        new_frame = 1'b1;
        if (with_sample) begin
            raw_x = 12'(x);
            raw_y = 12'(y);
            raw_z = 12'(z);
            sample_valid = 1'b1;
        end
        step();
        new_frame = 1'b0;
        sample_valid = 1'b0;
        e = exp_q.pop_front();
        chk({e.tag, ".x"}, int'(touch_x), e.x);
        chk({e.tag, ".y"}, int'(touch_y), e.y);
        chk({e.tag, ".down"}, int'(touch_down), e.down);
        chk({e.tag, ".valid"}, int'(touch_valid), e.valid);
        step();
        chk({e.tag, ".valid_drop"}, int'(touch_valid), 0);
    endtask

    initial begin
        #2;
        chk_all_zero("reset0");
        step();
        rstb = 1'b1;
        step();
        frame("idle_frame", 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) sample("bounce_p", 550, 700, 300, 0, 0);
        sample("bounce_r", 550, 700, 50, 0, 0);
        sample("bounce_after", 550, 700, 300, 0, 0);
        sample("bounce_r2", 550, 700, 50, 0, 0);
        frame("bounce_frame", 0, 0, 0, 0);

        for (int i = 0; i < 3; i++) sample("press_pend", 550, 700, 300, 0, 0);
        sample("press_4th", 550, 700, 300, 1, 0);
        step();
        chk("press_pulse_drop", int'(press_event), 0);
        chk("press_prepublish_x", int'(touch_x), 0);
        frame("press_frame", 100, 100, 1, 1);

        sample("avg1", 566, 700, 300, 0, 0);
        chk("avg1_held", int'(touch_x), 100);
        frame("avg1_frame", 101, 100, 1, 1);
        sample("avg2", 582, 700, 300, 0, 0);
        frame("avg2_frame", 103, 100, 1, 1);
        sample("avg3", 598, 700, 300, 0, 0);
        frame("avg3_frame", 106, 100, 1, 1);
        sample("avg4", 614, 700, 300, 0, 0);
        chk("avg4_held", int'(touch_x), 106);
        frame("avg4_frame", 110, 100, 1, 1);

        for (int i = 0; i < 4; i++) sample("sat_low", 100, 700, 300, 0, 0);
        frame("sat_frame", 0, 100, 1, 1);
        for (int i = 0; i < 4; i++) sample("clamp_high", 4095, 4095, 300, 0, 0);
        frame("clamp_frame", 479, 271, 1, 1);

        for (int i = 0; i < 10; i++) sample("hyst", 4095, 4095, 200, 0, 0);
        frame("hyst_frame", 479, 271, 1, 1);

        frame("same_cycle", 479, 271, 1, 1, 1'b1, 550, 700, 300);
        frame("same_cycle_next", 384, 228, 1, 1);

        for (int i = 0; i < 3; i++) sample("rel_pend", 550, 700, 100, 0, 0);
        chk("rel_pend_state_down_hold", int'(touch_down), 1);
        sample("rel_4th", 550, 700, 100, 0, 1);
        frame("release_frame", 384, 228, 0, 0);

        for (int i = 0; i < 3; i++) sample("repress", 550, 700, 300, 0, 0);
        sample("repress_4th", 550, 700, 300, 1, 0);
        frame("repress_frame", 100, 100, 1, 1);
        sample("pre_reset", 566, 700, 300, 0, 0);
        #2;
        rstb = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        step();
        chk("reset_no_release", int'(release_event), 0);
        rstb = 1'b1;
        step();
        frame("post_reset_frame", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/touch_point_filter.md
Name: touch_point_filter

Overview:
- Registered, parametrised conditioning stage between touchpad_controller raw outputs (x/y/z) and tft_driver touch inputs.
- Per-axis calibration: offset subtract, shift, saturate, clamp.
- Pressure detection with hysteresis and debounce, plus a moving-average filter.
- Coordinates and touch_down are published only on new_frame, so the display never sees a mid-frame update.

Parameters:
- RAW_W, 12, raw touch sample width
- OUT_X_W, 10, output x width
- OUT_Y_W, 9, output y width
- X_OFFSET, 150, raw x calibration offset
- Y_OFFSET, 300, raw y calibration offset
- X_SHIFT, 2, x right-shift scale
- Y_SHIFT, 2, y right-shift scale
- X_MAX, 479, x clamp ceiling
- Y_MAX, 271, y clamp ceiling
- Z_PRESS, 256, raw_z >= this is a pressed sample
- Z_RELEASE, 128, raw_z < this is a release sample; Z_RELEASE < Z_PRESS required
- DEBOUNCE, 4, consecutive qualifying samples needed to change state (>=1)
- AVG_LOG2, 2, moving-average depth is 2^AVG_LOG2

Ports:
- cclk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; raw_x/y/z hold a new sample
- raw_x  in  RAW_W  raw x
- raw_y  in  RAW_W  raw y
- raw_z  in  RAW_W  raw pressure
- new_frame  in  1  one-cycle frame-boundary strobe from tft_driver
- touch_x  out  OUT_X_W  frame-synchronous filtered x
- touch_y  out  OUT_Y_W  frame-synchronous filtered y
- touch_down  out  1  frame-synchronous touch status
- touch_valid  out  1  one-cycle pulse, cycle after new_frame, when touch_x/y were refreshed
- press_event  out  1  one-cycle pulse on debounced press
- release_event  out  1  one-cycle pulse on debounced release

Behaviour:
- Reset (rstb low, async): all outputs 0, state IDLE, counter 0, average buffers and sums 0.
- Samples are processed only on sample_valid cycles. All other inputs are ignored except new_frame.
- Conversion per axis, combinational:
  - d = raw - OFFSET, saturating at 0 (never wraps).
  - s = d >> SHIFT.
  - c = min(s, MAX), truncated to output width.
- Sample classes:
  - P: raw_z >= Z_PRESS.
  - R: raw_z < Z_RELEASE.
  - H: otherwise.
- State machine, counter cnt:
  - IDLE: P -> PRESS_PEND, cnt=1. If DEBOUNCE==1, go directly to PRESSED.
  - PRESS_PEND: P -> cnt+1. H or R -> IDLE, cnt=0.
  - PRESS_PEND, cnt reaches DEBOUNCE: -> PRESSED, press_event pulse. The qualifying sample prefills every average slot; sum = c << AVG_LOG2.
  - PRESSED: P or H -> push c into the average. R -> REL_PEND, cnt=1; the R sample is not averaged.
  - REL_PEND: R -> cnt+1. On reaching DEBOUNCE -> IDLE, release_event pulse.
  - REL_PEND: P or H -> PRESSED, cnt=0; that sample is pushed.
- Moving average per axis:
  - Circular buffer of 2^AVG_LOG2 entries; running sum of width OUT_W+AVG_LOG2.
  - Push: sum <= sum - oldest + c; write pointer advances and wraps modulo depth.
  - avg = sum >> AVG_LOG2, read combinationally from registers.
  - Latency: sample at edge t is reflected in avg after edge t.
- Frame publish, on a new_frame cycle:
  - touch_down <= (state == PRESSED or REL_PEND).
  - If that value is 1: touch_x/y <= avg, and touch_valid pulses next cycle. Otherwise touch_x/y hold.
- new_frame and sample_valid in the same cycle: publish uses the pre-sample avg/state; the sample is applied on the same edge.
- Event pulses assert the cycle after the causing sample edge. They are independent of new_frame.
- Async reset mid-press: immediate IDLE with all outputs 0, no release_event.

Decomposition:
- Package touch_pkg:
  - state enum {IDLE, PRESS_PEND, PRESSED, REL_PEND}.
  - sample-class enum {P, H, R}.
  - saturating subtract/clamp function.
- Sub-module moving_average:
  - Parameters: W, LOG2.
  - Ports: cclk, rstb, push, prefill, din, avg.
  - Instantiated once per axis.

Test Plan:
- Reset: assert rstb=0 mid-run -> all outputs 0 asynchronously. Release, then new_frame -> touch_down=0, touch_valid=0.
- Press with defaults: 4 samples of raw_z=300, raw_x=550, raw_y=700 -> press_event after 4th sample. Next new_frame -> touch_x=100, touch_y=100, touch_down=1, touch_valid pulse.
- Bounce: 3 samples raw_z=300, then raw_z=50 -> state IDLE, no press_event, touch_down stays 0.
- Saturation/clamp while pressed:
  - raw_x=100 -> touch_x=0.
  - raw_x=4095 -> 986 clamped to 479.
  - raw_y=4095 -> 948 clamped to 271.
- Averaging: press at raw_x=550 (x=100), then raw_x=566, 582, 598, 614 -> avg 101, 103, 106, 110. Each value is visible only after the following new_frame.
- Hysteresis/release:
  - While pressed, raw_z=200 for 10 samples -> remains pressed.
  - Then 4 samples raw_z=100 -> release_event. Next new_frame -> touch_down=0, touch_x/y hold last values, no touch_valid.
  - Same-cycle sample_valid+new_frame -> published value equals pre-sample avg.
